// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences a length-N unsigned dot product through an external
// registered 8x8 multiplier (product valid the cycle after mul_en).
// Operands arrive as a byte stream a0,b0,a1,b1,... on a valid/ready port; the
// accumulated sum leaves on a valid/ready result port together with an
// overflow flag.
// Optional build macro: MAC_SEQ_SATURATE_EN -- when defined, an accumulator
// carry-out clamps the sum to all ones instead of wrapping.
module mac_sequencer #(
  parameter int LEN_W = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  output logic             mul_en,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf,
  output logic             busy
);

  // The product must fit inside the accumulator.
  if (ACC_W < 16) begin : g_acc_w_check
    $error("mac_sequencer: ACC_W must be >= 16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_MUL,
    S_ACC,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic               ovf_reg;
  logic [LEN_W-1:0]   count_reg;
  logic [7:0]         mul_a_reg;
  logic [7:0]         mul_b_reg;
  logic               out_valid_reg;
  logic [ACC_W-1:0]   out_data_reg;

  // One extra bit catches the carry-out of the accumulation.
  logic [ACC_W:0]     sum;
  assign sum = {1'b0, acc_reg} + {{(ACC_W - 15){1'b0}}, mul_p};

  // Handshake strobes are pure state decodes, so neither in_valid nor
  // out_ready can reach an output combinationally.
  assign in_ready  = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B);
  assign mul_en    = (state_reg == S_MUL);
  assign busy      = (state_reg != S_IDLE);
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign ovf       = ovf_reg;

  // Sequencer: load A, load B, fire the multiplier, accumulate, repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      count_reg     <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            count_reg <= len;
            if (len == '0) state_reg <= S_DONE;
            else           state_reg <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (in_valid) begin
            mul_a_reg <= in_data;
            state_reg <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (in_valid) begin
            mul_b_reg <= in_data;
            state_reg <= S_MUL;
          end
        end
        S_MUL: begin
          // Operands are held here; the multiplier captures them this edge.
          state_reg <= S_ACC;
        end
        S_ACC: begin
`ifdef MAC_SEQ_SATURATE_EN
          // Once clamped, any further nonzero product carries out again,
          // so the accumulator stays at all ones for the rest of the job.
          if (sum[ACC_W]) acc_reg <= '1;
          else            acc_reg <= sum[ACC_W-1:0];
`else
          acc_reg <= sum[ACC_W-1:0];
`endif
          if (sum[ACC_W]) ovf_reg <= 1'b1;
          count_reg <= count_reg - 1'b1;
          if (count_reg == LEN_W'(1)) state_reg <= S_DONE;
          else                        state_reg <= S_LOAD_A;
        end
        S_DONE: begin
          // First DONE cycle publishes the result; it is then held until taken.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= acc_reg;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized and directed checks of mac_sequencer against a
// plain-arithmetic dot-product model. Built with ACC_W=16 so overflow is easy
// to reach. Honors MAC_SEQ_SATURATE_EN the same way the design does.
module tb_mac_sequencer;

  localparam int LEN_W = 4;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             mul_en;
  logic [15:0]      mul_p = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic             ovf;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int ir_cnt = 0;
  int ops [32];

  mac_sequencer #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered 8x8 multiplier the sequencer drives.
  always @(posedge clk) if (mul_en) mul_p <= mul_a * mul_b;

  // Edge counter plus strobe counters used for latency and pulse checks.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mul_en)   en_cnt <= en_cnt + 1;
    if (in_ready) ir_cnt <= ir_cnt + 1;
  end

  // Runs one job with operands from ops[], checks result against the model.
  task automatic do_job(input int n, input int gap, input int ordelay, input bit spam,
                        input int exp_lat, input string name,
                        output logic [ACC_W-1:0] got_d, output logic got_o);
    longint s;
    logic [ACC_W-1:0] exp_d;
    logic exp_o;
    logic [ACC_W-1:0] held;
    logic hovf;
    int e0, t, en0, ir0, lat;
    bit aborted;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(ops[2*i]) * longint'(ops[2*i+1]);
    exp_o = (s >= (longint'(1) << ACC_W));
    exp_d = ACC_W'(s % (longint'(1) << ACC_W));
`ifdef MAC_SEQ_SATURATE_EN
    if (exp_o) exp_d = '1;
`endif
    got_d = '0;
    got_o = 1'b0;
    aborted = 0;
    @(negedge clk);
    start = 1'b1;
    len = LEN_W'(n);
    out_ready = 1'b0;
    en0 = en_cnt;
    ir0 = ir_cnt;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    if (spam) len = LEN_W'(5);
    else start = 1'b0;
    for (int i = 0; i < 2*n && !aborted; i++) begin
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'(ops[i]);
      t = 0;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin
        checks++; failures++;
        $display("FAIL %s in_ready_timeout byte=%0d got in_ready=0 required 1", name, i);
        aborted = 1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
      end
    end
    t = 0;
    while (!aborted && !out_valid && t < 200) begin @(negedge clk); t++; end
    if (!aborted && t >= 200) begin
      checks++; failures++;
      $display("FAIL %s out_valid_timeout got out_valid=0 required 1", name);
      aborted = 1;
    end
    start = 1'b0;
    if (aborted) begin
      in_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      return;
    end
    lat = cyc - e0;
    if (exp_lat >= 0) begin
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL %s latency got edge %0d required edge %0d", name, lat, exp_lat);
      end
    end
    held = out_data;
    hovf = ovf;
    got_d = out_data;
    got_o = ovf;
    checks++;
    if (out_data !== exp_d) begin
      failures++;
      $display("FAIL %s out_data got %0d required %0d", name, out_data, exp_d);
    end
    checks++;
    if (ovf !== exp_o) begin
      failures++;
      $display("FAIL %s ovf got %0b required %0b", name, ovf, exp_o);
    end
    for (int k = 0; k < ordelay; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || ovf !== hovf) begin
        failures++;
        $display("FAIL %s hold_stable cyc=%0d got valid=%0b data=%0d ovf=%0b required 1/%0d/%0b",
                 name, k, out_valid, out_data, ovf, held, hovf);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_handshake got valid=%0b busy=%0b required 0/0", name, out_valid, busy);
    end
    checks++;
    if (en_cnt - en0 !== n) begin
      failures++;
      $display("FAIL %s mul_en_count got %0d required %0d", name, en_cnt - en0, n);
    end
    if (n == 0) begin
      checks++;
      if (ir_cnt - ir0 !== 0) begin
        failures++;
        $display("FAIL %s in_ready_cycles got %0d required 0", name, ir_cnt - ir0);
      end
    end
    $display("job %s len=%0d data=%0d ovf=%0b latency=%0d", name, n, got_d, got_o, lat);
  endtask

  task automatic test_reset();
    logic [36:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = {in_ready, mul_a, mul_b, mul_en, out_valid, out_data, ovf, busy};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL reset_values got %h required 0", v);
    end
    reset = 1'b0;
    $display("reset checked outputs=%h", v);
  endtask

  task automatic test_basic();
    logic [ACC_W-1:0] d; logic o;
    ops[0] = 3; ops[1] = 4; ops[2] = 5; ops[3] = 6;
    do_job(2, 0, 0, 0, 9, "basic", d, o);
    checks++;
    if (d !== 16'd42 || o !== 1'b0) begin
      failures++;
      $display("FAIL basic_known got %0d/%0b required 42/0", d, o);
    end
  endtask

  task automatic test_len_zero();
    logic [ACC_W-1:0] d; logic o;
    do_job(0, 0, 0, 0, 1, "len_zero", d, o);
    checks++;
    if (d !== '0 || o !== 1'b0) begin
      failures++;
      $display("FAIL len_zero_known got %0d/%0b required 0/0", d, o);
    end
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] d; logic o;
    logic [ACC_W-1:0] want;
`ifdef MAC_SEQ_SATURATE_EN
    want = 16'd65535;
`else
    want = 16'd64514;
`endif
    for (int i = 0; i < 4; i++) ops[i] = 255;
    do_job(2, 0, 0, 0, 9, "overflow", d, o);
    checks++;
    if (d !== want || o !== 1'b1) begin
      failures++;
      $display("FAIL overflow_known got %0d/%0b required %0d/1", d, o, want);
    end
  endtask

  task automatic test_gaps();
    logic [ACC_W-1:0] d; logic o;
    for (int i = 0; i < 6; i++) ops[i] = i + 1;
    do_job(3, 2, 3, 0, -1, "gaps", d, o);
    checks++;
    if (d !== 16'd44 || o !== 1'b0) begin
      failures++;
      $display("FAIL gaps_known got %0d/%0b required 44/0", d, o);
    end
  endtask

  task automatic test_start_spam();
    logic [ACC_W-1:0] d; logic o;
    ops[0] = 7; ops[1] = 9;
    do_job(1, 0, 0, 1, 5, "start_spam", d, o);
    checks++;
    if (d !== 16'd63) begin
      failures++;
      $display("FAIL start_spam_known got %0d required 63", d);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL start_spam_single got valid=%0b busy=%0b required 0/0", out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [ACC_W-1:0] d; logic o;
    logic [36:0] v;
    int t;
    @(negedge clk);
    start = 1'b1;
    len = LEN_W'(2);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'd200;
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(posedge clk);          // MUL -> ACC
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = {in_ready, mul_a, mul_b, mul_en, out_valid, out_data, ovf, busy};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL abort_reset_values got %h required 0", v);
    end
    reset = 1'b0;
    ops[0] = 2; ops[1] = 3;
    do_job(1, 0, 0, 0, 5, "after_abort", d, o);
    checks++;
    if (d !== 16'd6 || o !== 1'b0) begin
      failures++;
      $display("FAIL after_abort_known got %0d/%0b required 6/0", d, o);
    end
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] d; logic o;
    int n;
    for (int j = 0; j < 20; j++) begin
      n = (j == 19) ? 15 : int'($urandom_range(0, 8));
      for (int i = 0; i < 2*n; i++) ops[i] = int'($urandom_range(0, 255));
      do_job(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0, -1, "random", d, o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_overflow();
    test_gaps();
    test_start_spam();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
